// File: rtl/vc_credit_sender.sv
// vc_credit_sender: credit-based, round-robin virtual-channel link sender.
// Each VC owns a credit counter for its downstream buffer. Among requesting
// VCs that have credit, one is granted per cycle (round-robin), popped
// upstream through vc_grant and sent on the link one cycle later.
//
// Optional feature: define VC_CREDIT_ERR_EN to enable the sticky credit_err
// flag for credits returned to an already-full counter. Without it,
// credit_err is tied to 0.
//
// Ports:
//   clk           clock, rising edge
//   clr           asynchronous active-high reset
//   vc_req        per-VC "flit ready" from upstream
//   flit_in       packed per-VC flits, VC i at [i*FLIT_W +: FLIT_W]
//   credit_valid  one credit returned this cycle
//   credit_vc     VC index of the returned credit
//   vc_grant      combinational one-hot (or zero) pop to upstream
//   flit_out      registered flit to the link
//   flit_valid    registered flit_out qualifier
//   flit_vc       registered VC index of flit_out
//   credit_err    sticky credit-overflow flag
module vc_credit_sender #(
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned FLIT_W       = 16,
  parameter int unsigned CREDIT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NUM_VC-1:0]           vc_req,
  input  logic [NUM_VC*FLIT_W-1:0]    flit_in,
  input  logic                        credit_valid,
  input  logic [$clog2(NUM_VC)-1:0]   credit_vc,
  output logic [NUM_VC-1:0]           vc_grant,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        flit_valid,
  output logic [$clog2(NUM_VC)-1:0]   flit_vc,
  output logic                        credit_err
);

  localparam int unsigned VC_W  = $clog2(NUM_VC);
  localparam int unsigned CNT_W = $clog2(CREDIT_DEPTH + 1);

  localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CREDIT_DEPTH);
  localparam logic [VC_W-1:0]  PTR_RST   = VC_W'(NUM_VC - 1);

  logic [CNT_W-1:0]  credit_q [NUM_VC];
  logic [CNT_W-1:0]  credit_d [NUM_VC];
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic              flit_valid_q, flit_valid_d;
  logic [VC_W-1:0]   flit_vc_q, flit_vc_d;

  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] credit_ret;
  logic              grant_found;
  logic [VC_W-1:0]   grant_idx;
  logic [VC_W-1:0]   search_idx;

  // Eligibility uses registered credit, so a returned credit helps next cycle.
  always_comb begin
    eligible   = '0;
    credit_ret = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      eligible[i]   = vc_req[i] && (credit_q[i] != '0);
      credit_ret[i] = credit_valid && (credit_vc == VC_W'(i));
    end
  end

  // Round-robin search from rr_ptr+1; NUM_VC is a power of two so the
  // VC_W-bit add wraps modulo NUM_VC. Reset suppresses any grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    vc_grant    = '0;
    for (int unsigned k = 1; k <= NUM_VC; k++) begin
      search_idx = rr_ptr_q + VC_W'(k);
      if (!grant_found && eligible[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
    if (clr) begin
      grant_found = 1'b0;
    end
    if (grant_found) begin
      vc_grant[grant_idx] = 1'b1;
    end
  end

  // Pointer and link register next state; flit/vc hold when nothing is sent.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    flit_out_d   = flit_out_q;
    flit_vc_d    = flit_vc_q;
    flit_valid_d = grant_found;
    if (grant_found) begin
      rr_ptr_d  = grant_idx;
      flit_vc_d = grant_idx;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        if (vc_grant[i]) begin
          flit_out_d = flit_in[i*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  // Credit update: grant and return on the same VC cancel; a return to a
  // full counter is dropped (saturation).
  always_comb begin
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      credit_d[i] = credit_q[i];
      if (vc_grant[i] && !credit_ret[i]) begin
        credit_d[i] = credit_q[i] - CNT_W'(1);
      end else if (!vc_grant[i] && credit_ret[i]) begin
        if (credit_q[i] != CRED_FULL) begin
          credit_d[i] = credit_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        credit_q[i] <= CRED_FULL;
      end
      rr_ptr_q     <= PTR_RST;
      flit_out_q   <= '0;
      flit_valid_q <= 1'b0;
      flit_vc_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VC; i++) begin
        credit_q[i] <= credit_d[i];
      end
      rr_ptr_q     <= rr_ptr_d;
      flit_out_q   <= flit_out_d;
      flit_valid_q <= flit_valid_d;
      flit_vc_q    <= flit_vc_d;
    end
  end

  assign flit_out   = flit_out_q;
  assign flit_valid = flit_valid_q;
  assign flit_vc    = flit_vc_q;

`ifdef VC_CREDIT_ERR_EN
  logic credit_err_q, credit_err_d, credit_drop;

  // Flag a return that lands on a full counter with no same-cycle grant.
  always_comb begin
    credit_drop = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (credit_ret[i] && !vc_grant[i] && (credit_q[i] == CRED_FULL)) begin
        credit_drop = 1'b1;
      end
    end
    credit_err_d = credit_err_q | credit_drop;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      credit_err_q <= 1'b0;
    end else begin
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: doc/vc_credit_sender.md
VC_CREDIT_SENDER -- requirements
Module: vc_credit_sender

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: number of virtual channels, power of two, 2..8.
REQ-002 SHALL have parameter FLIT_W, default 16: flit width in bits.
REQ-003 SHALL have parameter CREDIT_DEPTH, default 4: downstream buffer slots per VC, 1..15.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port clr  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port vc_req  input  NUM_VC  bit i high means upstream VC i has a flit ready.
REQ-007 SHALL have port flit_in  input  NUM_VC*FLIT_W  flit for VC i in bits [i*FLIT_W +: FLIT_W].
REQ-008 SHALL have port credit_valid  input  1  downstream returns one credit this cycle.
REQ-009 SHALL have port credit_vc  input  log2(NUM_VC)  VC index of the returned credit.
REQ-010 SHALL have port vc_grant  output  NUM_VC  one-hot or zero, combinational; a high bit pops that upstream VC this cycle.
REQ-011 SHALL have port flit_out  output  FLIT_W  registered flit to the link.
REQ-012 SHALL have port flit_valid  output  1  registered; flit_out is valid.
REQ-013 SHALL have port flit_vc  output  log2(NUM_VC)  registered VC index of flit_out.
REQ-014 SHALL have port credit_err  output  1  sticky credit-overflow flag (see Configuration).

Function
REQ-015 SHALL keep one credit counter per VC, width ceil(log2(CREDIT_DEPTH+1)), range 0..CREDIT_DEPTH.
REQ-016 SHALL mark VC i eligible when vc_req[i]=1 and credit[i]>0.
REQ-017 SHALL grant at most one eligible VC per cycle by round-robin: search starts at rr_ptr+1 and wraps modulo NUM_VC.
REQ-018 SHALL set rr_ptr to the granted index on a grant, and leave it unchanged when there is no grant.
REQ-019 SHALL drive vc_grant=0 when no VC is eligible; a requesting VC with zero credit SHALL never be granted.
REQ-020 SHALL, on the edge after grant of VC g, present flit_out=flit_in[g], flit_vc=g and flit_valid=1; latency is 1 cycle.
REQ-021 SHALL hold flit_valid=0 in the cycle after any no-grant cycle; flit_out and flit_vc then hold their previous values.
REQ-022 SHALL decrement credit[g] by 1 on a grant of VC g.
REQ-023 SHALL increment credit[credit_vc] by 1 when credit_valid=1.
REQ-024 SHALL leave the counter unchanged (net 0) when the granted VC and credit_vc are the same VC in the same cycle.
REQ-025 SHALL base eligibility on the registered counter value, so a credit returned in cycle N enables a grant from cycle N+1.
REQ-026 SHALL ignore credit_valid when credit[credit_vc]==CREDIT_DEPTH and no same-cycle grant applies; the counter saturates.
REQ-027 SHALL sustain one flit per cycle when credits are available; back-to-back grants to the same VC are legal.

Reset
REQ-028 SHALL, while clr=1, force every credit to CREDIT_DEPTH, rr_ptr to NUM_VC-1 (VC0 has first priority), flit_valid to 0, flit_out to 0, flit_vc to 0 and credit_err to 0.
REQ-029 SHALL force vc_grant=0 while clr=1; a flit in flight is dropped.
REQ-030 SHALL grant normally from the first rising edge after clr deasserts.

Configuration
REQ-031 SHALL, when macro VC_CREDIT_ERR_EN is defined, set credit_err to 1 on any credit dropped under REQ-026; credit_err SHALL stay 1 until clr.
REQ-032 SHALL, when VC_CREDIT_ERR_EN is undefined, tie credit_err to 0 and include no extra state; credit behaviour is otherwise identical.

Verification
REQ-033 SHALL cover: reset, then vc_req=4'b0001 held with no credits returned -> exactly 4 grants to VC0 on consecutive cycles, then vc_grant=0 and flit_valid=0.
REQ-034 SHALL cover: vc_req=4'b1111 with full credits -> grant order VC0, VC1, VC2, VC3, VC0, ...; flit_vc follows the same order one cycle later.
REQ-035 SHALL cover: VC2 at credit 0 with vc_req=4'b0100 and credit_valid=1, credit_vc=2 in cycle N -> no grant in cycle N, grant to VC2 in cycle N+1.
REQ-036 SHALL cover: VC1 at credit 1 receiving a grant and a credit_valid with credit_vc=1 in the same cycle -> credit[1] remains 1.
REQ-037 SHALL cover: credit_valid with credit_vc=3 while credit[3]=4 -> credit[3] remains 4; credit_err=1 with VC_CREDIT_ERR_EN defined, 0 without it.
REQ-038 SHALL cover: clr asserted mid-stream with credits partially consumed -> immediate vc_grant=0 and flit_valid=0, all credits back to 4, first grant after release goes to the lowest requesting VC.
